// File: rtl/register_file.sv
// General-purpose register bank: one synchronous write port, two combinational read ports.
// There is no write-through bypass, so a same-cycle read returns the old value until the edge.
module register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int REG_COUNT  = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] WR_addr,
    input  logic [DATA_WIDTH-1:0] WR_data,
    input  logic [ADDR_WIDTH-1:0] RA_addr,
    input  logic [ADDR_WIDTH-1:0] RB_addr,
    output logic [DATA_WIDTH-1:0] RA_data,
    output logic [DATA_WIDTH-1:0] RB_data
);

    logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (WE) begin
            r_regs[WR_addr] <= WR_data;
        end
    end

    assign RA_data = r_regs[RA_addr];
    assign RB_data = r_regs[RB_addr];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, write/read, WE gating, full sweep,
// read-during-write and asynchronous reset in the middle of a write.
`timescale 1ns/1ps
module tb_register_file;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int RC = 8;

    logic          clk;
    logic          rst_n;
    logic          WE;
    logic [AW-1:0] WR_addr;
    logic [DW-1:0] WR_data;
    logic [AW-1:0] RA_addr;
    logic [AW-1:0] RB_addr;
    logic [DW-1:0] RA_data;
    logic [DW-1:0] RB_data;

    int n_checks = 0;
    int n_fail   = 0;

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .WE     (WE),
        .WR_addr(WR_addr),
        .WR_data(WR_data),
        .RA_addr(RA_addr),
        .RB_addr(RB_addr),
        .RA_data(RA_data),
        .RB_data(RB_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single write: set up after the falling edge, commit on the rising edge, drop WE.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        WE      = 1'b1;
        WR_addr = a;
        WR_data = d;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        WE      = 1'b0;
        WR_addr = '0;
        WR_data = '0;
        RA_addr = 3'd0;
        RB_addr = 3'd7;
        #100;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (RA_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_ra: got %h expected %h", RA_data, 16'h0000);
        end
        n_checks++;
        if (RB_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_rb: got %h expected %h", RB_data, 16'h0000);
        end
        // Every register must read 0 after reset.
        for (int i = 0; i < RC; i++) begin
            RA_addr = AW'(i);
            #1;
            n_checks++;
            if (RA_data !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %h expected %h", i, RA_data, 16'h0000);
            end
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        WE      = 1'b1;
        WR_addr = 3'd0;
        WR_data = 16'hABCD;
        @(negedge clk);
        WR_addr = 3'd1;
        WR_data = 16'h0123;
        @(posedge clk);
        #1;
        WE      = 1'b0;
        RA_addr = 3'd0;
        RB_addr = 3'd1;
        #1;
        n_checks++;
        if (RA_data !== 16'hABCD) begin
            n_fail++;
            $display("FAIL basic_ra: got %h expected %h", RA_data, 16'hABCD);
        end
        n_checks++;
        if (RB_data !== 16'h0123) begin
            n_fail++;
            $display("FAIL basic_rb: got %h expected %h", RB_data, 16'h0123);
        end
        RA_addr = 3'd2;
        #1;
        n_checks++;
        if (RA_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL basic_untouched: got %h expected %h", RA_data, 16'h0000);
        end
    endtask

    task automatic test_we_gating();
        @(negedge clk);
        WE      = 1'b0;
        WR_addr = 3'd0;
        WR_data = 16'hFFFF;
        repeat (4) @(posedge clk);
        #1;
        RA_addr = 3'd0;
        RB_addr = 3'd1;
        #1;
        n_checks++;
        if (RA_data !== 16'hABCD) begin
            n_fail++;
            $display("FAIL we_gating_reg0: got %h expected %h", RA_data, 16'hABCD);
        end
        n_checks++;
        if (RB_data !== 16'h0123) begin
            n_fail++;
            $display("FAIL we_gating_reg1: got %h expected %h", RB_data, 16'h0123);
        end
    endtask

    task automatic test_all_regs();
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        for (int i = 0; i < RC; i++) begin
            do_write(AW'(i), DW'(16'h1111 * (i + 1)));
        end
        for (int i = 0; i < RC; i++) begin
            RA_addr = AW'(i);
            RB_addr = AW'(RC - 1 - i);
            exp_a   = DW'(16'h1111 * (i + 1));
            exp_b   = DW'(16'h1111 * (RC - i));
            #1;
            n_checks++;
            if (RA_data !== exp_a) begin
                n_fail++;
                $display("FAIL sweep_ra[%0d]: got %h expected %h", i, RA_data, exp_a);
            end
            n_checks++;
            if (RB_data !== exp_b) begin
                n_fail++;
                $display("FAIL sweep_rb[%0d]: got %h expected %h", RC - 1 - i, RB_data, exp_b);
            end
        end
        for (int i = 0; i < RC; i++) begin
            RA_addr = AW'(i);
            RB_addr = AW'(i);
            exp_a   = DW'(16'h1111 * (i + 1));
            #1;
            n_checks++;
            if (RA_data !== exp_a || RB_data !== exp_a) begin
                n_fail++;
                $display("FAIL same_addr[%0d]: got A=%h B=%h expected %h", i, RA_data, RB_data, exp_a);
            end
        end
    endtask

    task automatic test_rdw();
        @(negedge clk);
        RA_addr = 3'd3;
        RB_addr = 3'd2;
        WE      = 1'b1;
        WR_addr = 3'd3;
        WR_data = 16'hBEEF;
        #1;
        n_checks++;
        if (RA_data !== 16'h4444) begin
            n_fail++;
            $display("FAIL rdw_before: got %h expected %h", RA_data, 16'h4444);
        end
        @(posedge clk);
        #1;
        WE = 1'b0;
        n_checks++;
        if (RA_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL rdw_after: got %h expected %h", RA_data, 16'hBEEF);
        end
        n_checks++;
        if (RB_data !== 16'h3333) begin
            n_fail++;
            $display("FAIL rdw_neighbor: got %h expected %h", RB_data, 16'h3333);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        RA_addr = 3'd3;
        RB_addr = 3'd5;
        #2;
        WE      = 1'b1;
        WR_addr = 3'd5;
        WR_data = 16'h1234;
        rst_n   = 1'b0;
        #1;
        n_checks++;
        if (RA_data !== 16'h0000 || RB_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got A=%h B=%h expected 0000", RA_data, RB_data);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (RB_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset_write_ignored: got %h expected %h", RB_data, 16'h0000);
        end
        @(negedge clk);
        WE    = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (RA_data !== 16'h0000 || RB_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset_hold: got A=%h B=%h expected 0000", RA_data, RB_data);
        end
        do_write(3'd5, 16'h5A5A);
        n_checks++;
        if (RB_data !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL post_reset_write: got %h expected %h", RB_data, 16'h5A5A);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_we_gating();
        test_all_regs();
        test_rdw();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
